// File: rtl/bus_gate_controller.sv
// Bus entry/exit gate sequencer: arbitrates entry/exit requests onto one door,
// validates rider ID and capacity, and owns the registered occupancy count.
module bus_gate_controller #(
  parameter int unsigned CAP        = 31,
  parameter int unsigned CNT_W      = 5,
  parameter int unsigned ID_W       = 8,
  parameter int unsigned DOOR_CYC   = 4,
  parameter int unsigned LIGHT_HOLD = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic [ID_W-1:0]  entry_id,
  input  logic [ID_W-1:0]  valid_id,
  input  logic             exit_req,
  output logic             entry_ack,
  output logic             entry_deny,
  output logic             exit_ack,
  output logic             exit_deny,
  output logic             door_open,
  output logic             busy,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             light
);

  localparam int unsigned TMR_W  = $clog2(DOOR_CYC + 1);
  localparam int unsigned HOLD_W = $clog2(LIGHT_HOLD + 1);
  localparam logic [CNT_W-1:0]  CAP_V  = CNT_W'(CAP);
  localparam logic [TMR_W-1:0]  DOOR_V = TMR_W'(DOOR_CYC);
  localparam logic [HOLD_W-1:0] HOLD_V = HOLD_W'(LIGHT_HOLD);

  typedef enum logic [2:0] {
    IDLE, CHECK, OPEN_IN, OPEN_OUT, DENY_IN, DENY_OUT
  } state_t;

  typedef enum logic {RR_ENTRY, RR_EXIT} rr_t;

  state_t            state, state_n;
  rr_t               rr_last, rr_n;
  logic [TMR_W-1:0]  tmr, tmr_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [CNT_W-1:0]  occ_n;
  logic              eack_n, edeny_n, xack_n, xdeny_n, door_n, light_n;
  logic              take_exit;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_last    <= RR_EXIT;
      tmr        <= '0;
      hold       <= '0;
      occupancy  <= '0;
      entry_ack  <= 1'b0;
      entry_deny <= 1'b0;
      exit_ack   <= 1'b0;
      exit_deny  <= 1'b0;
      door_open  <= 1'b0;
      busy       <= 1'b0;
      full       <= 1'b0;
      empty      <= 1'b1;
      light      <= 1'b0;
    end else begin
      state      <= state_n;
      rr_last    <= rr_n;
      tmr        <= tmr_n;
      hold       <= hold_n;
      occupancy  <= occ_n;
      entry_ack  <= eack_n;
      entry_deny <= edeny_n;
      exit_ack   <= xack_n;
      exit_deny  <= xdeny_n;
      door_open  <= door_n;
      busy       <= (state_n != IDLE);
      full       <= (occ_n == CAP_V);
      empty      <= (occ_n == '0);
      light      <= light_n;
    end
  end

  // Outputs are computed one state ahead so every port comes straight from a flop.
  always_comb begin
    state_n   = state;
    rr_n      = rr_last;
    tmr_n     = tmr;
    occ_n     = occupancy;
    eack_n    = 1'b0;
    edeny_n   = 1'b0;
    xack_n    = 1'b0;
    xdeny_n   = 1'b0;
    door_n    = door_open;
    take_exit = 1'b0;

    case (state)
      IDLE: begin
        door_n = 1'b0;
        if (entry_req || exit_req) begin
          // A full bus always lets someone out first; otherwise alternate.
          take_exit = exit_req && (!entry_req || full || (rr_last == RR_ENTRY));
          if (take_exit) begin
            rr_n = RR_EXIT;
            if (occupancy != '0) begin
              state_n = OPEN_OUT;
              xack_n  = 1'b1;
              occ_n   = occupancy - 1'b1;
              door_n  = 1'b1;
              tmr_n   = DOOR_V;
            end else begin
              state_n = DENY_OUT;
              xdeny_n = 1'b1;
            end
          end else begin
            rr_n    = RR_ENTRY;
            state_n = CHECK;
          end
        end
      end
      CHECK: begin
        if ((entry_id == valid_id) && (occupancy < CAP_V)) begin
          state_n = OPEN_IN;
          eack_n  = 1'b1;
          occ_n   = occupancy + 1'b1;
          door_n  = 1'b1;
          tmr_n   = DOOR_V;
        end else begin
          state_n = DENY_IN;
          edeny_n = 1'b1;
        end
      end
      OPEN_IN, OPEN_OUT: begin
        if (tmr == TMR_W'(1)) begin
          state_n = IDLE;
          door_n  = 1'b0;
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      DENY_IN, DENY_OUT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Light hold starts on the 1->0 occupancy step and is cancelled by any rider on board.
  always_comb begin
    hold_n = '0;
    if (occ_n != '0)
      hold_n = '0;
    else if (occupancy != '0)
      hold_n = HOLD_V;
    else if (hold != '0)
      hold_n = hold - 1'b1;
    light_n = (occ_n != '0) || (hold_n != '0);
  end

endmodule

// File: tb/tb_bus_gate_controller.sv
// Scoreboard bench for bus_gate_controller: stimulus queues expected pulses,
// a negedge monitor pops and compares kind, occupancy, full flag and cycle.
module tb_bus_gate_controller;

  localparam int CAP        = 31;
  localparam int CNT_W      = 5;
  localparam int ID_W       = 8;
  localparam int DOOR_CYC   = 4;
  localparam int LIGHT_HOLD = 8;

  logic             Clk, reset;
  logic             entry_req, exit_req;
  logic [ID_W-1:0]  entry_id, valid_id;
  logic             entry_ack, entry_deny, exit_ack, exit_deny;
  logic             door_open, busy, full, empty, light;
  logic [CNT_W-1:0] occupancy;

  bus_gate_controller #(
    .CAP(CAP), .CNT_W(CNT_W), .ID_W(ID_W), .DOOR_CYC(DOOR_CYC), .LIGHT_HOLD(LIGHT_HOLD)
  ) dut (
    .Clk(Clk), .reset(reset),
    .entry_req(entry_req), .entry_id(entry_id), .valid_id(valid_id), .exit_req(exit_req),
    .entry_ack(entry_ack), .entry_deny(entry_deny), .exit_ack(exit_ack), .exit_deny(exit_deny),
    .door_open(door_open), .busy(busy), .occupancy(occupancy),
    .full(full), .empty(empty), .light(light)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // code: 0 entry_ack, 1 entry_deny, 2 exit_ack, 3 exit_deny
  typedef struct {
    int code;
    int occ;
    int at;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_occ = 0;
  bit   m_rr_exit = 1'b1;
  int   door_runs = 0;
  int   exp_door_runs = 0;
  int   door_run = 0;
  int   last_ack = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout at cycle %0d", name, cyc);
  endtask

  always @(negedge Clk) begin
    int   code;
    exp_t e;
    code = -1;
    if (entry_ack)       code = 0;
    else if (entry_deny) code = 1;
    else if (exit_ack)   code = 2;
    else if (exit_deny)  code = 3;
    if (code >= 0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got code %0d expected none (cycle %0d)", code, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", code, e.code);
        check("pulse_occ", occupancy, e.occ);
        check("pulse_full", full, e.occ == CAP);
        check("pulse_cycle", cyc, e.at);
      end
    end
    if (!reset) door_run = 0;
    else if (door_open) door_run++;
    else if (door_run != 0) begin
      check("door_len", door_run, DOOR_CYC);
      door_runs++;
      door_run = 0;
    end
  end

  // Raise requests from an idle gate, queue the expected outcomes, drop each request on its pulse.
  task automatic drive(input bit en, input bit ex, input logic [ID_W-1:0] id, input logic [ID_W-1:0] vid);
    int  t;
    bit  first_entry, is_entry, grant;
    bit  ok;
    @(negedge Clk);
    t = cyc + 1;
    first_entry = (en && ex) ? ((m_occ != CAP) && m_rr_exit) : en;
    for (int k = 0; k < int'(en) + int'(ex); k++) begin
      is_entry = (k == 0) ? first_entry : !first_entry;
      grant = 1'b0;
      if (is_entry) begin
        m_rr_exit = 1'b0;
        t = t + 1;
        if (id == vid && m_occ < CAP) begin
          m_occ++;
          sb.push_back('{0, m_occ, t});
          grant = 1'b1;
        end else sb.push_back('{1, m_occ, t});
      end else begin
        m_rr_exit = 1'b1;
        if (m_occ > 0) begin
          m_occ--;
          sb.push_back('{2, m_occ, t});
          grant = 1'b1;
        end else sb.push_back('{3, m_occ, t});
      end
      if (grant) begin
        exp_door_runs++;
        last_ack = t;
      end
      t = t + (grant ? DOOR_CYC : 1) + 1;
    end
    entry_id  = id;
    valid_id  = vid;
    entry_req = en;
    exit_req  = ex;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge Clk);
      if (entry_req && (entry_ack || entry_deny)) entry_req = 1'b0;
      if (exit_req && (exit_ack || exit_deny)) exit_req = 1'b0;
      if (!entry_req && !exit_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeout("req_response");
      entry_req = 1'b0;
      exit_req  = 1'b0;
    end
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    if (!ok) timeout("busy_clear");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
    entry_id = '0; valid_id = '0;
    repeat (3) @(negedge Clk);
    check("rst_occ", occupancy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_light", light, 0);
    check("rst_door", door_open, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;

    // T1: valid entry
    drive(1, 0, 8'h6D, 8'h6D);
    check("t1_occ", occupancy, 1);
    check("t1_light", light, 1);
    check("t1_empty", empty, 0);

    // T2: bad ID
    drive(1, 0, 8'h6A, 8'h62);
    check("t2_occ", occupancy, 1);

    // T6a: last rider leaves, light holds then goes off
    drive(0, 1, 8'h00, 8'h00);
    check("t6_occ", occupancy, 0);
    while (cyc < last_ack + LIGHT_HOLD - 1) @(negedge Clk);
    check("t6_light_hold", light, 1);
    @(negedge Clk);
    check("t6_light_off", light, 0);

    // T4: exit from empty bus
    drive(0, 1, 8'h00, 8'h00);
    check("t4_occ", occupancy, 0);
    check("t4_empty", empty, 1);

    // T5: six in, one out (leaves rr on exit), then contested pairs alternate
    for (int i = 0; i < 6; i++) drive(1, 0, 8'h33, 8'h33);
    drive(0, 1, 8'h00, 8'h00);
    check("t5_start_occ", occupancy, 5);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 8'h33, 8'h33);
      check("t5_pair_occ", occupancy, 5);
    end

    // T3: fill to capacity, deny one more, then contested while full
    for (int i = 5; i < CAP; i++) drive(1, 0, 8'hA5, 8'hA5);
    check("t3_full", full, 1);
    check("t3_occ", occupancy, CAP);
    drive(1, 0, 8'hA5, 8'hA5);
    check("t3_full_occ", occupancy, CAP);
    drive(1, 1, 8'hA4, 8'hA5);
    check("t3_after_occ", occupancy, 30);
    check("t3_after_full", full, 0);

    // T6b: reset during OPEN_OUT
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    reset = 1'b1;
    m_occ = 0;
    m_rr_exit = 1'b1;
    check("t6b_rst_occ", occupancy, 0);
    drive(1, 0, 8'h11, 8'h11);
    check("t6b_occ", occupancy, 1);
    @(negedge Clk);
    sb.push_back('{2, 0, cyc + 1});
    exit_req = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      if (exit_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("t6b_exit_ack");
    exit_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t6b_async_occ", occupancy, 0);
    check("t6b_async_empty", empty, 1);
    check("t6b_async_full", full, 0);
    check("t6b_async_light", light, 0);
    check("t6b_async_door", door_open, 0);
    check("t6b_async_busy", busy, 0);
    check("t6b_async_ack", exit_ack, 0);
    @(negedge Clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("end_queue_empty", sb.size(), 0);
    check("end_door_runs", door_runs, exp_door_runs);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
